// File: rtl/pcap_dma_sequencer.sv
// Position-capture DMA sequencer: pops buffer addresses, issues write bursts from the capture FIFO,
// and raises one IRQ report per finished buffer. One burst in flight; request held until acknowledged.
module pcap_dma_sequencer #(
  parameter int TBL_AW    = 5,
  parameter int BURST_LEN = 16,
  parameter int FIFO_AW   = 10
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              enable_i,
  input  logic              abort_i,
  input  logic              addr_wr_i,
  input  logic [31:0]       addr_data_i,
  input  logic [31:0]       blocksize_i,
  input  logic [FIFO_AW:0]  fifo_count_i,
  output logic              dma_req_o,
  output logic [31:0]       dma_addr_o,
  output logic [7:0]        dma_len_o,
  input  logic              dma_ack_i,
  input  logic              dma_done_i,
  output logic              irq_o,
  output logic [7:0]        irq_flags_o,
  output logic [31:0]       irq_count_o,
  output logic [TBL_AW:0]   tbl_count_o,
  output logic              active_o
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WAIT, S_REQ, S_XFER, S_IRQ} state_t;

  localparam int                TBL_DEPTH  = 2 ** TBL_AW;
  localparam logic [TBL_AW:0]   TBL_FULL   = (TBL_AW + 1)'(TBL_DEPTH);
  localparam logic [7:0]        LEN_FULL   = 8'(BURST_LEN);
  localparam logic [FIFO_AW:0]  FIFO_BURST = (FIFO_AW + 1)'(BURST_LEN);
  localparam logic [7:0]        F_FULL     = 8'h01;
  localparam logic [7:0]        F_COMPLETE = 8'h02;
  localparam logic [7:0]        F_NO_ADDR  = 8'h04;
  localparam logic [7:0]        F_ABORT    = 8'h08;

  state_t              state;
  logic [31:0]         tbl_mem [TBL_DEPTH];
  logic [TBL_AW-1:0]   wr_ptr;
  logic [TBL_AW-1:0]   rd_ptr;
  logic [TBL_AW:0]     tbl_cnt;
  logic [31:0]         cur_addr;
  logic [31:0]         cur_cnt;
  logic [31:0]         blk_words;
  logic                abort_q;
  logic                push;
  logic                pop;
  logic                flush;
  logic                tbl_empty;
  logic [31:0]         next_cnt;
  logic                unused_ok;

  assign tbl_empty   = (tbl_cnt == '0);
  assign push        = addr_wr_i && (tbl_cnt != TBL_FULL);
  assign pop         = (state == S_LOAD) && !abort_q && !tbl_empty;
  assign flush       = (state == S_IRQ) && (irq_flags_o[2] || irq_flags_o[3]);
  assign next_cnt    = cur_cnt + {24'd0, dma_len_o};
  assign tbl_count_o = tbl_cnt;
  assign unused_ok   = ^{addr_data_i[1:0], blocksize_i[1:0]};

  always_ff @(posedge clk_i) begin
    if (push) tbl_mem[wr_ptr] <= {addr_data_i[31:2], 2'b00};
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      tbl_cnt <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      tbl_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      tbl_cnt <= tbl_cnt + 1'b1;
      else if (pop && !push) tbl_cnt <= tbl_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state       <= S_IDLE;
      cur_addr    <= '0;
      cur_cnt     <= '0;
      blk_words   <= '0;
      abort_q     <= 1'b0;
      dma_req_o   <= 1'b0;
      dma_addr_o  <= '0;
      dma_len_o   <= '0;
      irq_o       <= 1'b0;
      irq_flags_o <= '0;
      irq_count_o <= '0;
      active_o    <= 1'b0;
    end else begin
      if (abort_i && state != S_IDLE) abort_q <= 1'b1;
      case (state)
        S_IDLE: begin
          if (enable_i) begin
            state    <= S_LOAD;
            active_o <= 1'b1;
          end
        end
        S_LOAD: begin
          if (abort_q) begin
            state <= S_IRQ; irq_o <= 1'b1; irq_flags_o <= F_ABORT; irq_count_o <= '0;
          end else if (!tbl_empty) begin
            cur_addr  <= tbl_mem[rd_ptr];
            cur_cnt   <= '0;
            blk_words <= {2'b00, blocksize_i[31:2]};
            state     <= S_WAIT;
          end else begin
            state <= S_IRQ; irq_o <= 1'b1; irq_flags_o <= F_NO_ADDR; irq_count_o <= '0;
          end
        end
        S_WAIT: begin
          if (abort_q) begin
            state <= S_IRQ; irq_o <= 1'b1; irq_flags_o <= F_ABORT; irq_count_o <= cur_cnt;
          end else if (fifo_count_i >= FIFO_BURST) begin
            state <= S_REQ; dma_req_o <= 1'b1; dma_addr_o <= cur_addr; dma_len_o <= LEN_FULL;
          end else if (!enable_i && fifo_count_i != '0) begin
            // End-of-capture flush: the leftover is always shorter than a full burst here.
            state <= S_REQ; dma_req_o <= 1'b1; dma_addr_o <= cur_addr; dma_len_o <= fifo_count_i[7:0];
          end else if (!enable_i) begin
            state <= S_IRQ; irq_o <= 1'b1; irq_flags_o <= F_COMPLETE; irq_count_o <= cur_cnt;
          end
        end
        S_REQ: begin
          if (dma_ack_i) begin
            dma_req_o <= 1'b0;
            state     <= S_XFER;
          end
        end
        S_XFER: begin
          if (dma_done_i) begin
            cur_cnt  <= next_cnt;
            cur_addr <= cur_addr + {22'd0, dma_len_o, 2'b00};
            if (next_cnt == blk_words) begin
              state <= S_IRQ; irq_o <= 1'b1; irq_flags_o <= F_FULL; irq_count_o <= next_cnt;
            end else begin
              state <= S_WAIT;
            end
          end
        end
        S_IRQ: begin
          irq_o <= 1'b0;
          if (irq_flags_o[3]) abort_q <= 1'b0;
          // A full buffer rolls into a fresh one while capture runs or data is still pending.
          if (irq_flags_o[0] && (enable_i || fifo_count_i != '0)) begin
            state <= S_LOAD;
          end else begin
            state    <= S_IDLE;
            active_o <= 1'b0;
          end
        end
        default: begin
          state    <= S_IDLE;
          active_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pcap_dma_sequencer.sv
// Bench for pcap_dma_sequencer: buffer-level planner predicts bursts and reports; a negedge
// monitor checks every request and IRQ against it, plus literal spot checks per scenario.
module tb_pcap_dma_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable, abort, addr_wr, dma_ack, dma_done;
  logic [31:0] addr_data, blocksize;
  logic [10:0] fifo_count;
  logic        dma_req_o, irq_o, active_o;
  logic [31:0] dma_addr_o, irq_count_o;
  logic [7:0]  dma_len_o, irq_flags_o;
  logic [5:0]  tbl_count_o;

  always #5 clk = ~clk;

  pcap_dma_sequencer dut (
    .clk_i(clk), .reset_i(rst), .enable_i(enable), .abort_i(abort),
    .addr_wr_i(addr_wr), .addr_data_i(addr_data), .blocksize_i(blocksize),
    .fifo_count_i(fifo_count), .dma_req_o(dma_req_o), .dma_addr_o(dma_addr_o),
    .dma_len_o(dma_len_o), .dma_ack_i(dma_ack), .dma_done_i(dma_done),
    .irq_o(irq_o), .irq_flags_o(irq_flags_o), .irq_count_o(irq_count_o),
    .tbl_count_o(tbl_count_o), .active_o(active_o)
  );

  typedef struct packed { logic [31:0] a; logic [7:0] l; } burst_t;
  typedef struct packed { logic [7:0] f; logic [31:0] c; } rep_t;

  burst_t      exp_b[$];
  rep_t        exp_r[$];
  logic [31:0] tbl_model[$];
  int          checks = 0;
  int          fails  = 0;
  bit          chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Buffer-level expectation: fill each table buffer of blk words from n captured words.
  task automatic plan(input int blk, input int n);
    int rem, cnt, len;
    logic [31:0] a;
    rem = n;
    forever begin
      if (tbl_model.size() == 0) begin
        exp_r.push_back('{f: 8'h04, c: 32'd0});
        tbl_model.delete();
        break;
      end
      a = tbl_model.pop_front();
      cnt = 0;
      while (cnt < blk && rem > 0) begin
        len = (rem >= 16) ? 16 : rem;
        exp_b.push_back('{a: a + 32'(cnt * 4), l: 8'(len)});
        cnt += len;
        rem -= len;
      end
      if (cnt == blk) begin
        exp_r.push_back('{f: 8'h01, c: 32'(cnt)});
        if (rem == 0) break;
      end else begin
        exp_r.push_back('{f: 8'h02, c: 32'(cnt)});
        break;
      end
    end
  endtask

  burst_t      eb;
  rep_t        er;
  logic        req_prev = 1'b0, irq_prev = 1'b0;
  logic [31:0] hold_a;
  logic [7:0]  hold_l;

  always @(negedge clk) begin
    if (chk_en && !rst) begin
      if (dma_req_o) begin
        check("req_active", 32'(active_o), 32'd1);
        if (!req_prev) begin
          check("burst_expected", 32'(exp_b.size() != 0), 32'd1);
          if (exp_b.size() != 0) begin
            eb = exp_b.pop_front();
            check("burst_addr", dma_addr_o, eb.a);
            check("burst_len", 32'(dma_len_o), 32'(eb.l));
          end
          hold_a = dma_addr_o;
          hold_l = dma_len_o;
        end else begin
          check("req_addr_stable", dma_addr_o, hold_a);
          check("req_len_stable", 32'(dma_len_o), 32'(hold_l));
        end
      end
      if (irq_o) begin
        check("irq_single_pulse", 32'(irq_prev), 32'd0);
        check("irq_expected", 32'(exp_r.size() != 0), 32'd1);
        if (exp_r.size() != 0) begin
          er = exp_r.pop_front();
          check("irq_flags", 32'(irq_flags_o), 32'(er.f));
          check("irq_count", irq_count_o, er.c);
        end
      end
    end
    req_prev = dma_req_o;
    irq_prev = irq_o;
  end

  task automatic push(input logic [31:0] a);
    addr_wr = 1'b1;
    addr_data = a;
    @(posedge clk); #1;
    addr_wr = 1'b0;
    if (tbl_model.size() < 32) tbl_model.push_back({a[31:2], 2'b00});
  endtask

  // Drives capture FIFO level and the AXI master; enable drops once less than a burst remains.
  task automatic run_scn(input int ack_dly, input int n, input bit do_abort);
    int rem, ph, w, cyc;
    logic [7:0] l;
    rem = n; ph = 0; w = 0; cyc = 0; l = '0;
    fifo_count = 11'(n);
    enable = 1'b1;
    while (cyc < 3000) begin
      @(posedge clk); #1;
      cyc++;
      dma_ack = 1'b0; dma_done = 1'b0; abort = 1'b0;
      if (rem < 16) enable = 1'b0;
      if (exp_r.size() == 0 && !active_o && ph == 0) break;
      if (ph == 0) begin
        if (dma_req_o) begin
          if (w == ack_dly) begin
            dma_ack = 1'b1; l = dma_len_o; ph = 1; w = 0;
          end else w++;
        end
      end else begin
        w++;
        if (do_abort && w == 1) begin abort = 1'b1; enable = 1'b0; end
        if (w == 2) begin
          dma_done = 1'b1;
          rem -= int'(l);
          fifo_count = 11'(rem);
          ph = 0; w = 0;
        end
      end
    end
    dma_ack = 1'b0; dma_done = 1'b0; abort = 1'b0; enable = 1'b0;
    check("scenario_in_budget", 32'(cyc < 3000), 32'd1);
    check("bursts_left", 32'(exp_b.size()), 32'd0);
    check("tbl_count_model", 32'(tbl_count_o), 32'(tbl_model.size()));
  endtask

  initial begin
    int cyc;
    rst = 1'b1; enable = 1'b0; abort = 1'b0; addr_wr = 1'b0; addr_data = '0;
    blocksize = '0; fifo_count = '0; dma_ack = 1'b0; dma_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req", 32'(dma_req_o), 32'd0);
    check("rst_irq", 32'(irq_o), 32'd0);
    check("rst_flags", 32'(irq_flags_o), 32'd0);
    check("rst_count", irq_count_o, 32'd0);
    check("rst_tbl", 32'(tbl_count_o), 32'd0);
    check("rst_active", 32'(active_o), 32'd0);
    check("rst_addr", dma_addr_o, 32'd0);
    rst = 1'b0;
    chk_en = 1'b1;

    // 1: two buffers of 32 words, 64 words captured; low address bits dropped
    push(32'h1000); push(32'h2002);
    check("t1_tbl_two", 32'(tbl_count_o), 32'd2);
    blocksize = 32'd128;
    plan(32, 64);
    run_scn(0, 64, 1'b0);
    check("t1_flags", 32'(irq_flags_o), 32'h01);
    check("t1_count", irq_count_o, 32'd32);

    // 2: end of capture with 5 words left after one full burst
    push(32'h3000);
    plan(32, 21);
    run_scn(1, 21, 1'b0);
    check("t2_flags", 32'(irq_flags_o), 32'h02);
    check("t2_count", irq_count_o, 32'd21);

    // 3: enable with empty table
    plan(32, 0);
    fifo_count = '0;
    enable = 1'b1;
    @(posedge clk); #1;
    check("t3_no_irq_yet", 32'(irq_o), 32'd0);
    @(posedge clk); #1;
    check("t3_irq_2cyc", 32'(irq_o), 32'd1);
    enable = 1'b0;
    @(posedge clk); #1;
    check("t3_idle", 32'(active_o), 32'd0);
    check("t3_flags", 32'(irq_flags_o), 32'h04);
    check("t3_count", irq_count_o, 32'd0);

    // 4: abort during the first burst; burst finishes, table flushed
    push(32'h4000); push(32'h4100);
    exp_b.push_back('{a: 32'h4000, l: 8'd16});
    exp_r.push_back('{f: 8'h08, c: 32'd16});
    tbl_model.delete();
    run_scn(0, 64, 1'b1);
    check("t4_flags", 32'(irq_flags_o), 32'h08);
    check("t4_count", irq_count_o, 32'd16);
    check("t4_tbl", 32'(tbl_count_o), 32'd0);
    check("t4_active", 32'(active_o), 32'd0);

    // abort while idle must not stick
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;

    // 5: table overflow and a slow acknowledge
    for (int i = 0; i < 33; i++) push(32'h10000 + 32'(i * 256));
    check("t5_tbl_full", 32'(tbl_count_o), 32'd32);
    blocksize = 32'd64;
    plan(16, 16);
    run_scn(10, 16, 1'b0);
    check("t5_flags", 32'(irq_flags_o), 32'h01);
    check("t5_tbl_after", 32'(tbl_count_o), 32'd31);

    // 6: reset while requesting, then restart
    chk_en = 1'b0;
    fifo_count = 11'd64;
    enable = 1'b1;
    cyc = 0;
    while (!dma_req_o && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("t6_req_seen", 32'(dma_req_o), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("t6_req_cleared", 32'(dma_req_o), 32'd0);
    check("t6_irq_cleared", 32'(irq_o), 32'd0);
    check("t6_active_cleared", 32'(active_o), 32'd0);
    check("t6_tbl_cleared", 32'(tbl_count_o), 32'd0);
    enable = 1'b0;
    fifo_count = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_b.delete(); exp_r.delete(); tbl_model.delete();
    @(posedge clk); #1;
    chk_en = 1'b1;
    push(32'h5000);
    plan(16, 16);
    run_scn(0, 16, 1'b0);
    check("t6_flags", 32'(irq_flags_o), 32'h01);
    check("t6_count", irq_count_o, 32'd16);
    check("t6_active", 32'(active_o), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
